// File: rtl/sfifo_wconv.sv
// -----------------------------------------------------------------------------
// sfifo_wconv - single-clock width-converting FIFO
//
// Stores data as UNIT-wide slices (UNIT = narrower of the two buses) so the
// same array serves wide-to-narrow and narrow-to-wide conversion. Lane order
// inside a wide word is selected by LSB_FIRST. FWFT selects registered reads
// (data one cycle after rd_en) or first-word-fall-through.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of pointers, count and sticky flags
//   wr_en, wr_data  write request / write word
//   wr_full         fewer than WR_U free units
//   almost_full     wr_water_level >= ALMOST_FULL_NUM
//   wr_water_level  occupied write-word slots (partial words count as used)
//   rd_en, rd_data  read request / read word
//   rd_empty        fewer than RD_U stored units
//   almost_empty    rd_water_level <= ALMOST_EMPTY_NUM
//   rd_water_level  complete read words available
//   overflow        sticky: write attempted while wr_full
//   underflow       sticky: read attempted while rd_empty
// -----------------------------------------------------------------------------
module sfifo_wconv #(
    parameter int WR_DATA_WIDTH    = 32,
    parameter int RD_DATA_WIDTH    = 8,
    parameter int WR_DEPTH_WIDTH   = 6,
    parameter int LSB_FIRST        = 1,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = 60,
    parameter int ALMOST_EMPTY_NUM = 4,
    localparam int UNIT     = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH,
    localparam int WR_U     = WR_DATA_WIDTH / UNIT,
    localparam int RD_U     = RD_DATA_WIDTH / UNIT,
    localparam int WR_WORDS = 1 << WR_DEPTH_WIDTH,
    localparam int DEPTH_U  = WR_WORDS * WR_U,
    localparam int RD_DEPTH_WIDTH = $clog2(DEPTH_U / RD_U)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WR_DATA_WIDTH-1:0]   wr_data,
    output logic                       wr_full,
    output logic                       almost_full,
    output logic [WR_DEPTH_WIDTH:0]    wr_water_level,
    input  logic                       rd_en,
    output logic [RD_DATA_WIDTH-1:0]   rd_data,
    output logic                       rd_empty,
    output logic                       almost_empty,
    output logic [RD_DEPTH_WIDTH:0]    rd_water_level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH_U);
    localparam int CNT_W = PTR_W + 1;
    localparam int WR_SH = $clog2(WR_U);
    localparam int RD_SH = $clog2(RD_U);

    logic [UNIT-1:0]          r_mem [DEPTH_U];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_cnt_u;
    logic                     r_overflow;
    logic                     r_underflow;
    logic [CNT_W-1:0]         w_free_u;
    logic                     w_wr_acc;
    logic                     w_rd_acc;
    logic [RD_DATA_WIDTH-1:0] w_head;

    // Flags derive purely from the registered unit count.
    assign w_free_u       = CNT_W'(DEPTH_U) - r_cnt_u;
    assign wr_full        = w_free_u < CNT_W'(WR_U);
    assign rd_empty       = r_cnt_u < CNT_W'(RD_U);
    assign rd_water_level = (RD_DEPTH_WIDTH+1)'(r_cnt_u >> RD_SH);
    // Free space is rounded down to whole write words, so a partially filled
    // word slot still counts as occupied on the write side.
    assign wr_water_level = (WR_DEPTH_WIDTH+1)'(WR_WORDS)
                          - (WR_DEPTH_WIDTH+1)'(w_free_u >> WR_SH);
    assign almost_full    = int'(wr_water_level) >= ALMOST_FULL_NUM;
    assign almost_empty   = int'(rd_water_level) <= ALMOST_EMPTY_NUM;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;

    // Flush wins over both requests in the same cycle.
    assign w_wr_acc = wr_en & ~wr_full  & ~flush;
    assign w_rd_acc = rd_en & ~rd_empty & ~flush;

    // NOTE: the storage array has no reset; contents are unreachable until
    // rewritten because pointers and count are reset, and leaving it out keeps
    // the array a plain register file without a reset tree.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int k = 0; k < WR_U; k++) begin
                r_mem[r_wr_ptr + PTR_W'(k)] <=
                    wr_data[((LSB_FIRST != 0) ? k : (WR_U - 1 - k)) * UNIT +: UNIT];
            end
        end
    end

    // Head read word assembled from RD_U consecutive units in lane order.
    // NOTE: default assignment first so every bit is driven on every path and
    // no latch is inferred.
    always_comb begin
        w_head = '0;
        for (int j = 0; j < RD_U; j++) begin
            w_head[((LSB_FIRST != 0) ? j : (RD_U - 1 - j)) * UNIT +: UNIT] =
                r_mem[r_rd_ptr + PTR_W'(j)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt_u     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt_u     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(WR_U);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(RD_U);
            // A same-cycle read does not create room for the write; both
            // decisions were already taken from the pre-edge count.
            if (w_wr_acc | w_rd_acc) begin
                r_cnt_u <= r_cnt_u
                         + (w_wr_acc ? CNT_W'(WR_U) : CNT_W'(0))
                         - (w_rd_acc ? CNT_W'(RD_U) : CNT_W'(0));
            end
            if (wr_en & wr_full)  r_overflow  <= 1'b1;
            if (rd_en & rd_empty) r_underflow <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented as soon as it is complete; rd_en pops it.
            assign rd_data = w_head;
        end else begin : g_std
            logic [RD_DATA_WIDTH-1:0] r_rd_data;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data <= '0;
                end else if (w_rd_acc) begin
                    r_rd_data <= w_head;
                end
            end
            assign rd_data = r_rd_data;
        end
    endgenerate

endmodule
